ins_fetch: RTL and testbench

- Instruction fetch unit: the requester side of the instruction-memory read port.
- Drives a word-aligned PC to the instruction memory and captures the returned instruction in the same cycle; the read is combinational.
- Buffers {pc, instruction} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch redirects from execute; a redirect flushes the buffer and reloads the PC.

---
 rtl/ins_fetch.sv | 125 ++++++++++++
 tb/tb_ins_fetch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetch.sv
// Instruction fetch unit: drives a word-aligned PC, captures the combinational instruction
// return into a small {pc, ins} FIFO and hands entries to decode; optional FETCH_PERF_EN counters.
`timescale 1ns/1ps
module ins_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      pc,
  input  logic [31:0]      ins,
  input  logic             br_valid,
  input  logic [31:0]      br_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ins,
  output logic [31:0]      out_pc,
  output logic [CNT_W-1:0] fifo_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetch,
  output logic [31:0]      perf_stall
`endif
);

  localparam int unsigned      PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]      PC_INIT  = {RESET_PC[31:2], 2'b00};

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_mem  [FIFO_DEPTH];
  logic [31:0]      ins_mem [FIFO_DEPTH];
  logic             full, pop, push;

  assign pc         = pc_q;
  assign fifo_count = cnt_q;
  assign out_valid  = (cnt_q != '0);
  assign out_pc     = pc_mem[rd_ptr_q];
  assign out_ins    = ins_mem[rd_ptr_q];

  always_comb begin
    full     = (cnt_q == FULL_CNT);
    pop      = out_valid & out_ready;
    push     = ~br_valid & (~full | pop);
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (br_valid) begin
      // Redirect wins: flush everything, drop any concurrent pop, refetch from target.
      pc_d     = {br_target[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= PC_INIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]  <= '0;
        ins_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr_q]  <= pc_q;
      ins_mem[wr_ptr_q] <= ins;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;

  // Counters survive redirects; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (push) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (~br_valid & full & ~pop) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_ins_fetch.sv
// Scoreboard bench for ins_fetch: a queue-based reference model predicts buffer contents,
// a negedge monitor compares and consumes the head whenever decode accepts it.
`timescale 1ns/1ps
module tb_ins_fetch;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, ins, br_target, out_ins, out_pc;
  logic        br_valid, out_valid, out_ready;
  logic [1:0]  fifo_count;
  logic [31:0] w_pc, w_ins, w_out_ins, w_out_pc;
  logic        w_valid;
  logic [1:0]  w_count;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch, perf_stall, w_perf_fetch, w_perf_stall;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hE000_0000 + (a >> 2);
  endfunction

  assign ins   = mem(pc);
  assign w_ins = mem(w_pc);

  ins_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH), .CNT_W(2)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .ins        (ins),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ins    (out_ins),
    .out_pc     (out_pc),
    .fifo_count (fifo_count)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch (perf_fetch),
    .perf_stall (perf_stall)
`endif
  );

  ins_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH), .CNT_W(2)) u_wrap (
    .clk        (clk),
    .rst        (rst),
    .pc         (w_pc),
    .ins        (w_ins),
    .br_valid   (1'b0),
    .br_target  (32'h0),
    .out_valid  (w_valid),
    .out_ready  (1'b1),
    .out_ins    (w_out_ins),
    .out_pc     (w_out_pc),
    .fifo_count (w_count)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch (w_perf_fetch),
    .perf_stall (w_perf_stall)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffer is a queue of {pc, ins}; the monitor removes accepted heads.
  logic [63:0] sbq[$];
  logic [31:0] mpc, mfetch, mstall;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sbq.delete();
      mpc    = 32'h0;
      mfetch = 32'h0;
      mstall = 32'h0;
    end else if (br_valid) begin
      sbq.delete();
      mpc = {br_target[31:2], 2'b00};
    end else if (sbq.size() < DEPTH) begin
      sbq.push_back({mpc, mem(mpc)});
      mpc    = mpc + 32'd4;
      mfetch = mfetch + 32'd1;
    end else begin
      mstall = mstall + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
      check("fifo_count", 32'(fifo_count), 32'(sbq.size()));
      check("pc", pc, mpc);
      if (out_valid && sbq.size() != 0) begin
        check("out_pc", out_pc, sbq[0][63:32]);
        check("out_ins", out_ins, sbq[0][31:0]);
        if (out_ready && !br_valid) void'(sbq.pop_front());
      end
`ifdef FETCH_PERF_EN
      check("perf_fetch", perf_fetch, mfetch);
      check("perf_stall", perf_stall, mstall);
`endif
    end
  end

  // Wrap-around instance: expected out_pc sequence from RESET_PC = FFFFFFF8.
  logic [31:0] w_exp [4];
  int widx;
  initial begin
    w_exp[0] = 32'hFFFF_FFF8;
    w_exp[1] = 32'hFFFF_FFFC;
    w_exp[2] = 32'h0000_0000;
    w_exp[3] = 32'h0000_0004;
  end

  always @(negedge clk) begin
    if (rst) begin
      widx = 0;
    end else if (w_valid && widx < 4) begin
      check("wrap_out_pc", w_out_pc, w_exp[widx]);
      check("wrap_out_ins", w_out_ins, mem(w_exp[widx]));
      widx++;
    end
  end

  task automatic step(input logic rdy, input logic br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    out_ready = rdy;
    br_valid  = br;
    br_target = tgt;
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    br_valid  = 1'b0;
    br_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_fifo_count", 32'(fifo_count), 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_ins", out_ins, 32'h0);
    check("rst_wrap_pc", w_pc, 32'hFFFF_FFF8);
    rst       = 1'b0;
    out_ready = 1'b1;

    // Streaming, then stall to full, then drain.
    repeat (6) step(1'b1, 1'b0, 32'h0);
    repeat (6) step(1'b0, 1'b0, 32'h0);
    repeat (5) step(1'b1, 1'b0, 32'h0);

    // Redirect while full and stalled.
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0103);
    step(1'b0, 1'b0, 32'h0);
    repeat (4) step(1'b1, 1'b0, 32'h0);

    // Redirect coinciding with a pop from a full buffer, then back-to-back redirects.
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0200);
    repeat (3) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0400);
    step(1'b1, 1'b1, 32'h0000_0802);
    repeat (3) step(1'b1, 1'b0, 32'h0);

    // PC wrap via redirect.
    step(1'b1, 1'b1, 32'hFFFF_FFF5);
    repeat (5) step(1'b1, 1'b0, 32'h0);

    repeat (400) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), $urandom);

    // Asynchronous reset while full and stalled.
    repeat (4) step(1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_fifo_count", 32'(fifo_count), 32'h0);
    check("arst_pc", pc, 32'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (8) step(1'b1, 1'b0, 32'h0);

    check("wrap_seen", 32'(widx), 32'd4);
`ifdef FETCH_PERF_EN
    check("wrap_perf_stall", w_perf_stall, 32'h0);
    check("wrap_perf_fetch_nonzero", 32'(w_perf_fetch != 0), 32'h1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
